// File: rtl/pmc_seq_pkg.sv
// Shared types and encodings for the pixel-matrix control sequencer.
// State codes are plain constants so the netlist encoding stays fixed across tool versions.
package pmc_seq_pkg;

  localparam int unsigned OpW    = 2;
  localparam int unsigned StateW = 4;
  localparam int unsigned DivW   = 8;

  typedef enum logic [OpW-1:0] {
    OpShift  = 2'b00,
    OpStrobe = 2'b01,
    OpGate   = 2'b10,
    OpSample = 2'b11
  } pmc_op_t;

  typedef logic [StateW-1:0] pmc_state_t;

  localparam pmc_state_t StIdle    = 4'd0;
  localparam pmc_state_t StLoad    = 4'd1;
  localparam pmc_state_t StShLo    = 4'd2;
  localparam pmc_state_t StShHi    = 4'd3;
  localparam pmc_state_t StStore   = 4'd4;
  localparam pmc_state_t StPulse   = 4'd5;
  localparam pmc_state_t StSampA   = 4'd6;
  localparam pmc_state_t StSampGap = 4'd7;
  localparam pmc_state_t StSampB   = 4'd8;
  localparam pmc_state_t StDone    = 4'd9;

endpackage

// File: rtl/pmc_sequencer_if.sv
// Command and shift-data handshake between the PMC register front end and the sequencer.
interface pmc_sequencer_if #(
  parameter int unsigned DIN_W = 64,
  parameter int unsigned CNT_W = 16
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_len;
  logic             abort;
  logic             wr_valid;
  logic             wr_ready;
  logic [DIN_W-1:0] wr_data;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_op, cmd_len, abort, wr_valid, wr_data,
    input  cmd_ready, wr_ready, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, abort, wr_valid, wr_data,
    output cmd_ready, wr_ready, busy, done
  );

endinterface

// File: rtl/pmc_sh_clkgen.sv
// Half-period timer for the matrix shift clock; phase is the registered pm_clk_sh level.
module pmc_sh_clkgen
  import pmc_seq_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic en,
  input  logic stop,
  output logic phase,
  output logic tc
);

  localparam logic [DivW-1:0] Last = DivW'(CLK_DIV - 1);

  logic [DivW-1:0] div_q, div_d;
  logic            phase_q, phase_d;

  assign tc    = en && (div_q == Last);
  assign phase = phase_q;

  always_comb begin
    div_d   = div_q;
    phase_d = phase_q;
    if (stop || start) begin
      div_d   = '0;
      phase_d = 1'b0;
    end else if (en) begin
      if (tc) begin
        div_d   = '0;
        phase_d = ~phase_q;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/pmc_sequencer.sv
// Pixel-matrix controller: runs one SHIFT/STROBE/GATE/SAMPLE command at a time and drives
// registered matrix strobes, shift clock and configuration data.
module pmc_sequencer
  import pmc_seq_pkg::*;
#(
  parameter int unsigned DIN_W   = 64,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  pmc_sequencer_if.slave   bus,
  output logic [DIN_W-1:0] pm_din,
  output logic             pm_clk_sh,
  output logic             pm_store,
  output logic             pm_strobe,
  output logic             pm_gate,
  output logic             pm_sh_a,
  output logic             pm_sh_b
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  pmc_state_t       state_q, state_d;
  pmc_op_t          op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [DIN_W-1:0] din_d;
  logic             accept, kill, load_word, sh_en, sh_tc;

  assign accept = bus.cmd_valid && (state_q == StIdle);
  assign kill   = bus.abort && (state_q != StIdle);
  assign sh_en  = (state_q == StShLo) || (state_q == StShHi);

  assign bus.cmd_ready = (state_q == StIdle) && !rst;
  assign bus.wr_ready  = (state_q == StLoad);
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    din_d     = pm_din;
    load_word = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d  = pmc_op_t'(bus.cmd_op);
          len_d = bus.cmd_len;
          cnt_d = bus.cmd_len;
          if (bus.cmd_len == '0) begin
            state_d = StDone;
          end else begin
            unique case (op_d)
              OpShift:          state_d = StLoad;
              OpStrobe, OpGate: state_d = StPulse;
              OpSample:         state_d = StSampA;
              default:          state_d = StDone;
            endcase
          end
        end
      end
      StLoad: begin
        if (bus.wr_valid) begin
          din_d     = bus.wr_data;
          load_word = 1'b1;
          state_d   = StShLo;
        end
      end
      StShLo: begin
        if (sh_tc) state_d = StShHi;
      end
      StShHi: begin
        // Word count drops only once the high half-period has fully elapsed.
        if (sh_tc) begin
          cnt_d   = cnt_q - CntOne;
          state_d = (cnt_q == CntOne) ? StStore : StLoad;
        end
      end
      StStore: state_d = StDone;
      StPulse, StSampB: begin
        if (cnt_q == CntOne) state_d = StDone;
        else                 cnt_d   = cnt_q - CntOne;
      end
      StSampA: begin
        if (cnt_q == CntOne) begin
          state_d = StSampGap;
          cnt_d   = len_q;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StSampGap: state_d = StSampB;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    if (kill) begin
      state_d = StIdle;
      din_d   = pm_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= OpShift;
      cnt_q     <= '0;
      len_q     <= '0;
      pm_din    <= '0;
      pm_store  <= 1'b0;
      pm_strobe <= 1'b0;
      pm_gate   <= 1'b0;
      pm_sh_a   <= 1'b0;
      pm_sh_b   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      pm_din    <= din_d;
      pm_store  <= (state_d == StStore);
      pm_strobe <= (state_d == StPulse) && (op_d == OpStrobe);
      pm_gate   <= (state_d == StPulse) && (op_d == OpGate);
      pm_sh_a   <= (state_d == StSampA);
      pm_sh_b   <= (state_d == StSampB);
    end
  end

  pmc_sh_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk   (clk),
    .rst   (rst),
    .start (load_word && !kill),
    .en    (sh_en),
    .stop  (kill),
    .phase (pm_clk_sh),
    .tc    (sh_tc)
  );

endmodule

// File: tb/tb_pmc_sequencer.sv
// Cycle-accurate trace checks of pmc_sequencer against a timeline model built from command rules.
module tb_pmc_sequencer;

  localparam int unsigned DIN_W   = 64;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CLK_DIV = 4;

  typedef struct packed {
    logic             busy;
    logic             done;
    logic             cmd_ready;
    logic             wr_ready;
    logic             clk_sh;
    logic             store;
    logic             strobe;
    logic             gate;
    logic             sh_a;
    logic             sh_b;
    logic [DIN_W-1:0] din;
  } snap_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [DIN_W-1:0] pm_din;
  logic             pm_clk_sh, pm_store, pm_strobe, pm_gate, pm_sh_a, pm_sh_b;

  pmc_sequencer_if #(.DIN_W(DIN_W), .CNT_W(CNT_W)) ifc ();

  pmc_sequencer #(
    .DIN_W   (DIN_W),
    .CNT_W   (CNT_W),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (ifc),
    .pm_din    (pm_din),
    .pm_clk_sh (pm_clk_sh),
    .pm_store  (pm_store),
    .pm_strobe (pm_strobe),
    .pm_gate   (pm_gate),
    .pm_sh_a   (pm_sh_a),
    .pm_sh_b   (pm_sh_b)
  );

  always #5 clk = ~clk;

  int               tests  = 0;
  int               failed = 0;
  snap_t            exp_q[$];
  snap_t            obs_q[$];
  logic [DIN_W-1:0] words_a[256];
  int               stall_a[256];
  logic [DIN_W-1:0] cur_din = '0;

  function automatic snap_t snap();
    snap_t s;
    s.busy = ifc.busy;       s.done = ifc.done;
    s.cmd_ready = ifc.cmd_ready; s.wr_ready = ifc.wr_ready;
    s.clk_sh = pm_clk_sh;    s.store = pm_store;
    s.strobe = pm_strobe;    s.gate = pm_gate;
    s.sh_a = pm_sh_a;        s.sh_b = pm_sh_b;
    s.din = pm_din;
    return s;
  endfunction

  function automatic snap_t base(input logic [DIN_W-1:0] d, input logic b);
    snap_t s;
    s = '0;
    s.busy = b;
    s.cmd_ready = !b;
    s.din = d;
    return s;
  endfunction

  // Expected per-cycle outputs from the cycle after acceptance through the following idle cycle.
  task automatic build_exp(input logic [1:0] op, input int len);
    snap_t            s;
    logic [DIN_W-1:0] d = cur_din;
    exp_q.delete();
    if (len != 0) begin
      case (op)
        2'b00: for (int w = 0; w < len; w++) begin
          s = base(d, 1'b1); s.wr_ready = 1'b1;
          repeat (stall_a[w] + 1) exp_q.push_back(s);
          d = words_a[w];
          s = base(d, 1'b1);
          repeat (CLK_DIV) exp_q.push_back(s);
          s.clk_sh = 1'b1;
          repeat (CLK_DIV) exp_q.push_back(s);
          if (w == len - 1) begin
            s = base(d, 1'b1); s.store = 1'b1; exp_q.push_back(s);
          end
        end
        2'b01: begin s = base(d, 1'b1); s.strobe = 1'b1; repeat (len) exp_q.push_back(s); end
        2'b10: begin s = base(d, 1'b1); s.gate = 1'b1; repeat (len) exp_q.push_back(s); end
        default: begin
          s = base(d, 1'b1); s.sh_a = 1'b1; repeat (len) exp_q.push_back(s);
          exp_q.push_back(base(d, 1'b1));
          s = base(d, 1'b1); s.sh_b = 1'b1; repeat (len) exp_q.push_back(s);
        end
      endcase
    end
    s = base(d, 1'b1); s.done = 1'b1; exp_q.push_back(s);
    exp_q.push_back(base(d, 1'b0));
  endtask

  // kill_kind: 0 abort, 1 rst, 2 both; asserted after observation kill_at (0 = none).
  task automatic run_cmd(input logic [1:0] op, input int len, input int kill_at,
                         input int kill_kind, input logic abort_with_cmd);
    int               n, wi, scnt;
    logic [DIN_W-1:0] kd;
    build_exp(op, len);
    if (kill_at > 0) begin
      kd = (kill_kind == 0) ? exp_q[kill_at-1].din : '0;
      while (exp_q.size() > kill_at) void'(exp_q.pop_back());
      exp_q.push_back(base(kd, 1'b0));
    end
    n = exp_q.size();
    obs_q.delete();
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op    = op;
    ifc.cmd_len   = len[CNT_W-1:0];
    ifc.abort     = abort_with_cmd;
    wi   = 0;
    scnt = stall_a[0];
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      ifc.cmd_valid = 1'b0;
      ifc.abort     = 1'b0;
      rst           = 1'b0;
      @(negedge clk);
      obs_q.push_back(snap());
      if (ifc.wr_ready) begin
        if (scnt > 0) begin
          ifc.wr_valid = 1'b0;
          scnt--;
        end else begin
          ifc.wr_valid = 1'b1;
          ifc.wr_data  = words_a[wi];
          wi++;
          scnt = (wi < 256) ? stall_a[wi] : 0;
        end
      end else begin
        ifc.wr_valid = 1'b0;
      end
      if (k == kill_at) begin
        if (kill_kind != 1) ifc.abort = 1'b1;
        if (kill_kind != 0) rst = 1'b1;
      end
    end
    cur_din = exp_q[n-1].din;
  endtask

  task automatic clear_stalls();
    for (int i = 0; i < 256; i++) stall_a[i] = 0;
  endtask

  task automatic test_reset();
    ifc.cmd_valid = 1'b0; ifc.cmd_op = 2'b00; ifc.cmd_len = '0; ifc.abort = 1'b0;
    ifc.wr_valid = 1'b0;  ifc.wr_data = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (snap() !== snap_t'('0)) begin
      failed++; $display("FAIL reset_hold got %h exp %h", snap(), snap_t'('0));
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (snap() !== base('0, 1'b0)) begin
      failed++; $display("FAIL reset_release got %h exp %h", snap(), base('0, 1'b0));
    end
    cur_din = '0;
  endtask

  task automatic test_shift3();
    clear_stalls();
    words_a[0] = {16{4'hA, 4'h5}} ; words_a[1] = {16{4'h0, 4'hF}}; words_a[2] = '1;
    run_cmd(2'b00, 3, 0, 0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        failed++; $display("FAIL shift3 cyc %0d got %h exp %h", i + 1, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_shift_stall();
    clear_stalls();
    stall_a[1] = 10;
    words_a[0] = 64'h0123_4567_89AB_CDEF; words_a[1] = 64'hFEDC_BA98_7654_3210;
    run_cmd(2'b00, 2, 0, 0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        failed++; $display("FAIL shift_stall cyc %0d got %h exp %h", i + 1, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_cmd(2'b01, 5, 0, 0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        failed++; $display("FAIL b2b_strobe cyc %0d got %h exp %h", i + 1, obs_q[i], exp_q[i]);
      end
    end
    run_cmd(2'b10, 1, 0, 0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        failed++; $display("FAIL b2b_gate cyc %0d got %h exp %h", i + 1, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_sample3();
    run_cmd(2'b11, 3, 0, 0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        failed++; $display("FAIL sample3 cyc %0d got %h exp %h", i + 1, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_abort();
    clear_stalls();
    for (int i = 0; i < 4; i++) words_a[i] = {$urandom, $urandom};
    // Word 2 high half spans observations 15..18.
    run_cmd(2'b00, 4, 16, 0, 1'b0);
    run_cmd(2'b01, 2, 0, 0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        failed++; $display("FAIL abort_after cyc %0d got %h exp %h", i + 1, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_abort_shift_trace();
    clear_stalls();
    for (int i = 0; i < 4; i++) words_a[i] = {$urandom, $urandom};
    run_cmd(2'b00, 4, 16, 0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        failed++; $display("FAIL abort_shhi cyc %0d got %h exp %h", i + 1, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_zero_len();
    for (int op = 0; op < 4; op++) begin
      run_cmd(op[1:0], 0, 0, 0, 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
        tests++;
        if (obs_q[i] !== exp_q[i]) begin
          failed++;
          $display("FAIL zero_len op %0d cyc %0d got %h exp %h", op, i + 1, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_rst_mid_gate();
    for (int kind = 1; kind <= 2; kind++) begin
      run_cmd(2'b10, 10, 4, kind, 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
        tests++;
        if (obs_q[i] !== exp_q[i]) begin
          failed++;
          $display("FAIL rst_gate k%0d cyc %0d got %h exp %h", kind, i + 1, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_abort_idle();
    run_cmd(2'b01, 3, 0, 0, 1'b1);
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        failed++; $display("FAIL abort_idle cyc %0d got %h exp %h", i + 1, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_max_len();
    clear_stalls();
    for (int i = 0; i < 256; i++) words_a[i] = {$urandom, $urandom};
    for (int op = 0; op < 4; op++) begin
      run_cmd(op[1:0], 255, 0, 0, 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
        tests++;
        if (obs_q[i] !== exp_q[i]) begin
          failed++;
          $display("FAIL max_len op %0d cyc %0d got %h exp %h", op, i + 1, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] op;
    int         len, m;
    for (int t = 0; t < 40; t++) begin
      op  = 2'($urandom_range(0, 3));
      len = $urandom_range(0, 12);
      for (int i = 0; i < 16; i++) begin
        stall_a[i] = $urandom_range(0, 3);
        words_a[i] = {$urandom, $urandom};
      end
      build_exp(op, len);
      m = ($urandom_range(0, 3) == 0) ? $urandom_range(1, exp_q.size() - 1) : 0;
      run_cmd(op, len, m, 0, 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
        tests++;
        if (obs_q[i] !== exp_q[i]) begin
          failed++;
          $display("FAIL random t%0d op %0d len %0d cyc %0d got %h exp %h",
                   t, op, len, i + 1, obs_q[i], exp_q[i]);
        end
        tests++;
        if ($countones({obs_q[i].store, obs_q[i].strobe, obs_q[i].gate,
                        obs_q[i].sh_a, obs_q[i].sh_b}) > 1) begin
          failed++;
          $display("FAIL onehot t%0d cyc %0d got %h exp at most one strobe", t, i + 1, obs_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_shift3();
    test_shift_stall();
    test_back_to_back();
    test_sample3();
    test_abort_shift_trace();
    test_abort();
    test_zero_len();
    test_rst_mid_gate();
    test_abort_idle();
    test_max_len();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
